// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle adder controller.
// Adds two WIDTH-bit operands by running one 4-bit ripple-carry slice over
// WIDTH/4 cycles. The carry between slices is kept in a register. A start/done
// handshake faces the requester, and the result is held until the next accepted start.

module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;          // index of the slice being added
    logic             carry_reg;  // carry chained from the previous slice
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [KW+1:0]    base;       // bit offset of slice k
    logic [4:0]       sum5;       // {c_next, sum4}

    // The shared 4-bit ripple-carry slice works on the operand nibbles picked by k.
    always_comb begin
        base = {k, 2'b00};
        sum5 = {1'b0, a_reg[base +: 4]} + {1'b0, b_reg[base +: 4]} + {4'b0000, carry_reg};
    end

    // Sequencer. It accepts operands in IDLE, adds one slice per ADD cycle,
    // and pulses done for one cycle in DONE.
    // NOTE: all state here uses non-blocking assignments. Every register then
    // updates from the values seen before the edge, so slice k and k+1 never mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the operand registers are cleared on reset as well. They
            // are plain flops, not a memory, so the cost is nothing.
            state     <= IDLE;
            k         <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        k         <= '0;
                        s         <= '0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    s[base +: 4] <= sum5[3:0];
                    carry_reg    <= sum5[4];
                    if (k == K_LAST) begin
                        co    <= sum5[4];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl. It covers a WIDTH=16 instance and a WIDTH=4 instance.
// Expected sums come from plain full-width arithmetic. Expected timing comes
// from the handshake rules: done follows the accepting edge by NSLICE edges.

module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        start, ci;
    logic [15:0] a, b;
    logic        busy, done, co;
    logic [15:0] s;

    logic        start4, ci4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, co4;
    logic [3:0]  s4;

    int tests_run    = 0;
    int tests_failed = 0;

    rca_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co)
    );

    rca_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model16(logic [15:0] x, logic [15:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    function automatic logic [4:0] model4(logic [3:0] x, logic [3:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + 5'(c);
    endfunction

    // Drives one WIDTH=16 operation from IDLE and reports what was observed.
    // lat counts the edges after the accepting edge until done is seen.
    task automatic do_add16(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                            input bit poke, output int lat, output logic [15:0] s0,
                            output logic [15:0] sres, output logic cres,
                            output logic [15:0] shold, output logic chold,
                            output int ndone, output int busy_cyc, output bit timeout);
        bit finished = 0;
        lat = -1; ndone = 0; busy_cyc = 0; sres = 'x; cres = 1'bx;
        start = 1'b1; a = xa; b = xb; ci = xc;
        tick();
        start = 1'b0;
        s0 = s;
        for (int e = 0; e < 20; e++) begin
            if (busy) busy_cyc++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = e;
                sres = s;
                cres = co;
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            if (poke && (e == 1 || e == 2)) begin
                start = 1'b1; a = 16'h1111; b = 16'h1111; ci = 1'b1;
            end else begin
                start = 1'b0; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            end
            tick();
        end
        timeout = !finished;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            tick();
            if (done) ndone++;
        end
        shold = s;
        chold = co;
    endtask

    task automatic do_add4(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                           output int lat, output logic [3:0] sres, output logic cres,
                           output int ndone, output bit timeout);
        bit finished = 0;
        lat = -1; ndone = 0; sres = 'x; cres = 1'bx;
        start4 = 1'b1; a4 = xa; b4 = xb; ci4 = xc;
        tick();
        start4 = 1'b0;
        for (int e = 0; e < 10; e++) begin
            if (done4) begin
                ndone++;
                if (lat < 0) lat = e;
                sres = s4;
                cres = co4;
            end
            if (!busy4) begin
                finished = 1;
                break;
            end
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            tick();
        end
        timeout = !finished;
        tick();
        if (done4) ndone++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 0; a = 0; b = 0; ci = 0;
        start4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        tick();
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (s !== 16'h0) begin tests_failed++; $display("FAIL reset_s got=%h exp=0000", s); end
        tests_run++; if (co !== 1'b0) begin tests_failed++; $display("FAIL reset_co got=%b exp=0", co); end
        tests_run++; if ({busy4, done4, s4, co4} !== 7'b0) begin tests_failed++; $display("FAIL reset_w4 got=%b exp=0", {busy4, done4, s4, co4}); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nd, bc; bit to; logic [15:0] s0, sr, sh; logic cr, ch;
        do_add16(16'h1234, 16'h0F0F, 1'b0, 0, lat, s0, sr, cr, sh, ch, nd, bc, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout busy never dropped"); end
        tests_run++; if (s0 !== 16'h0) begin tests_failed++; $display("FAIL basic_s_cleared got=%h exp=0000", s0); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        tests_run++; if (bc !== 5) begin tests_failed++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
        tests_run++; if ({cr, sr} !== 17'h02143) begin tests_failed++; $display("FAIL basic_sum got=%b_%h exp=0_2143", cr, sr); end
        tests_run++; if ({ch, sh} !== 17'h02143) begin tests_failed++; $display("FAIL basic_hold got=%b_%h exp=0_2143", ch, sh); end
    endtask

    task automatic test_carry_chain();
        int lat, nd, bc; bit to; logic [15:0] s0, sr, sh; logic cr, ch;
        do_add16(16'hFFFF, 16'h0001, 1'b0, 0, lat, s0, sr, cr, sh, ch, nd, bc, to);
        tests_run++; if ({cr, sr} !== 17'h10000) begin tests_failed++; $display("FAIL carry_ripple got=%b_%h exp=1_0000", cr, sr); end
        tests_run++; if ({ch, sh} !== 17'h10000) begin tests_failed++; $display("FAIL carry_ripple_hold got=%b_%h exp=1_0000", ch, sh); end
        do_add16(16'h0003, 16'h0002, 1'b1, 0, lat, s0, sr, cr, sh, ch, nd, bc, to);
        tests_run++; if ({cr, sr} !== 17'h00006) begin tests_failed++; $display("FAIL carry_in got=%b_%h exp=0_0006", cr, sr); end
        tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL carry_in_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_start_while_busy();
        int lat, nd, bc; bit to; logic [15:0] s0, sr, sh; logic cr, ch;
        do_add16(16'h0001, 16'h0002, 1'b0, 1, lat, s0, sr, cr, sh, ch, nd, bc, to);
        tests_run++; if ({cr, sr} !== 17'h00003) begin tests_failed++; $display("FAIL busy_start_sum got=%b_%h exp=0_0003", cr, sr); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL busy_start_done_count got=%0d exp=1", nd); end
        tests_run++; if ({ch, sh} !== 17'h00003) begin tests_failed++; $display("FAIL busy_start_hold got=%b_%h exp=0_0003", ch, sh); end
    endtask

    task automatic test_random();
        int lat, nd, bc; bit to; logic [15:0] s0, sr, sh; logic cr, ch;
        logic [15:0] xa, xb; logic xc; logic [16:0] exp;
        for (int i = 0; i < 16; i++) begin
            xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
            exp = model16(xa, xb, xc);
            do_add16(xa, xb, xc, 0, lat, s0, sr, cr, sh, ch, nd, bc, to);
            tests_run++; if ({cr, sr} !== exp) begin tests_failed++; $display("FAIL random_sum %h+%h+%b got=%h exp=%h", xa, xb, xc, {cr, sr}, exp); end
            tests_run++; if (lat !== 4 || nd !== 1) begin tests_failed++; $display("FAIL random_timing got lat=%0d done=%0d exp lat=4 done=1", lat, nd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        int last_done = -1;
        int ndone = 0;
        int low_run = 0;
        start = 1'b1; a = 16'h8000; b = 16'h8000; ci = 1'b0;
        exp = model16(a, b, ci);
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (done) begin
                tests_run++; if ({co, s} !== exp) begin tests_failed++; $display("FAIL b2b_sum #%0d got=%h exp=%h", ndone, {co, s}, exp); end
                if (last_done >= 0) begin
                    tests_run++; if (cyc - last_done !== 6) begin tests_failed++; $display("FAIL b2b_period got=%0d exp=6", cyc - last_done); end
                end
                last_done = cyc;
                ndone++;
                if (ndone >= 2) begin
                    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
                end
            end
            if (!busy) begin
                low_run++;
                exp = model16(a, b, ci);
            end else begin
                if (low_run > 0) begin
                    tests_run++; if (low_run !== 1) begin tests_failed++; $display("FAIL b2b_idle_gap got=%0d exp=1", low_run); end
                end
                low_run = 0;
            end
        end
        tests_run++; if (ndone !== 6) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=6", ndone); end
        start = 1'b0;
        for (int i = 0; i < 12 && busy; i++) tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain busy stuck high"); end
    endtask

    task automatic test_reset_mid_add();
        int lat, nd, bc; bit to; logic [15:0] s0, sr, sh; logic cr, ch;
        start = 1'b1; a = 16'h00FF; b = 16'h0001; ci = 1'b0;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        tests_run++; if ({busy, done, co, s} !== 19'h0) begin tests_failed++; $display("FAIL abort_immediate got busy=%b done=%b co=%b s=%h exp all 0", busy, done, co, s); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_hold got busy=%b done=%b exp 0 0", busy, done); end
        end
        reset = 1'b0;
        do_add16(16'h00FF, 16'h0001, 1'b0, 0, lat, s0, sr, cr, sh, ch, nd, bc, to);
        tests_run++; if ({cr, sr} !== 17'h00100) begin tests_failed++; $display("FAIL abort_rerun_sum got=%b_%h exp=0_0100", cr, sr); end
        tests_run++; if (lat !== 4 || nd !== 1) begin tests_failed++; $display("FAIL abort_rerun_timing got lat=%0d done=%0d exp lat=4 done=1", lat, nd); end
    endtask

    task automatic test_width4();
        int lat, nd; bit to; logic [3:0] sr; logic cr;
        logic [3:0] xa, xb; logic xc; logic [4:0] exp;
        do_add4(4'd9, 4'd8, 1'b1, lat, sr, cr, nd, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL w4_timeout busy never dropped"); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL w4_latency got=%0d exp=1", lat); end
        tests_run++; if ({cr, sr} !== 5'h12) begin tests_failed++; $display("FAIL w4_sum got=%b_%h exp=1_2", cr, sr); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL w4_done_count got=%0d exp=1", nd); end
        for (int i = 0; i < 8; i++) begin
            xa = 4'($urandom); xb = 4'($urandom); xc = 1'($urandom);
            exp = model4(xa, xb, xc);
            do_add4(xa, xb, xc, lat, sr, cr, nd, to);
            tests_run++; if ({cr, sr} !== exp || lat !== 1) begin tests_failed++; $display("FAIL w4_random %h+%h+%b got=%h lat=%0d exp=%h lat=1", xa, xb, xc, {cr, sr}, lat, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_start_while_busy();
        test_random();
        test_back_to_back();
        test_reset_mid_add();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
